fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline. Owns the PC and the IF/ID pipeline register, and drives the instruction memory address.
- Applies static BTFN prediction: backward branches are predicted taken, forward branches not taken. JAL is resolved at fetch.
- Consumes the decode stage's stall request and its PC-redirect (npc_control / jump_target_PC) for mispredicts and JALR.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble (addi x0,x0,0) inserted into IF/ID on flush and reset.

Ports:
- clk  input  1  clock
- rstn  input  1  asynchronous active-low reset
- imem_addr  output  32  fetch address (equals PC), combinational-read instruction memory
- imem_rdata  input  32  instruction at imem_addr, same cycle
- stall_in  input  1  decode wait request; hold PC and IF/ID
- redirect_valid  input  1  decode npc_control; load redirect_pc
- redirect_pc  input  32  decode jump_target_PC
- pc_dec  output  32  PC of instruction in IF/ID
- instruction_dec  output  32  instruction in IF/ID
- valid_dec  output  1  IF/ID holds a real (non-bubble) instruction
- pred_taken_dec  output  1  fetch redirected the PC for this instruction (JAL or backward branch)
- redirect_cnt  output  16  perf counter (see Optional Feature)
- stall_cnt  output  16  perf counter (see Optional Feature)

Behaviour:
- Reset (async, rstn=0): PC=RESET_PC; instruction_dec=NOP_INSTR; pc_dec=0; valid_dec=0; pred_taken_dec=0; counters=0.
- imem_addr = PC, combinational.
- Predecode of imem_rdata, combinational:
  - opcode 1101111 (JAL): target = PC + sext(J-imm), taken=1.
  - opcode 1100011 (B) with imm[12]=1: target = PC + sext(B-imm), taken=1.
  - otherwise: target = PC+4, taken=0.
  - JALR is fetched as PC+4; decode redirects it.
- Per rising edge, in priority order:
  1. redirect_valid=1: PC<=redirect_pc; IF/ID<=NOP_INSTR, valid_dec<=0, pred_taken_dec<=0. This overrides stall_in, which never legally coincides with a redirect.
  2. stall_in=1: PC and all IF/ID outputs hold.
  3. Otherwise: PC<=target; instruction_dec<=imem_rdata; pc_dec<=PC; valid_dec<=1; pred_taken_dec<=taken.
- Arithmetic is 32-bit, wrap-around modulo 2^32. No alignment check; bits [1:0] pass through unchanged.
- One-cycle fetch latency: an instruction at PC appears on instruction_dec the cycle after PC is presented.
- A redirect costs exactly one bubble cycle.
- A stall of N cycles holds the same instruction_dec for N+1 cycles total.
- If reset is asserted mid-stall or mid-redirect, all in-flight state is discarded.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - redirect_cnt increments on every cycle with redirect_valid=1.
  - stall_cnt increments on every cycle with stall_in=1 and redirect_valid=0.
  - Both counters saturate at 16'hFFFF.
- Undefined: redirect_cnt and stall_cnt are tied to 0 and no counter flops exist.

Decomposition:
- Shared package/defines:
  - opcode constants OPC_JAL and OPC_BRANCH (same values as the existing B_TYPE define).
  - NOP_INSTR encoding.
  - RESET_PC default.
- One sub-module, fetch_predecode: combinational. Inputs pc and instr; outputs target and taken. Performs immediate extraction and the BTFN decision.

Test Plan:
- Reset then straight-line ALU instructions: PC steps 0,4,8. The cycle after release gives pc_dec=0, valid_dec=1, instruction_dec = memory word at 0.
- JAL 0x010000EF at PC=0x20: next PC=0x30; pc_dec=0x20, pred_taken_dec=1; no bubble.
- Backward beq 0xFE000CE3 at PC=0x40: next PC=0x38, pred_taken_dec=1. Then redirect_valid=1, redirect_pc=0x44 → PC=0x44 and one NOP bubble (valid_dec=0).
- stall_in=1 for 3 cycles with instruction_dec=I at 0x10: PC, pc_dec and instruction_dec frozen for those 3 cycles. Resumes at 0x14; stall_cnt=3 when the macro is on.
- redirect_valid=1 and stall_in=1 in the same cycle, redirect_pc=0x100: PC=0x100, bubble inserted, stall ignored, redirect_cnt+1.
- rstn pulsed low mid-stream at PC=0x80: PC=0 immediately, valid_dec=0, instruction_dec=0x00000013. Counters clear.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_pkg
// Description : Shared constants and immediate helpers for the RV32I fetch
//               stage (opcodes, bubble encoding, reset PC).
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_stage_pkg;

  localparam logic [6:0]  OPC_JAL          = 7'b1101111;
  localparam logic [6:0]  OPC_BRANCH       = 7'b1100011;
  localparam logic [31:0] NOP_INSTR_ENC    = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Sign-extended J-type immediate (JAL offset).
  function automatic logic [31:0] sext_j_imm(input logic [31:0] instr);
    return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

  // Sign-extended B-type immediate (conditional branch offset).
  function automatic logic [31:0] sext_b_imm(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_predecode.sv
`default_nettype none
// ============================================================================
// Module      : fetch_predecode
// Description : Combinational predecode of the fetched word. Resolves JAL and
//               applies static BTFN prediction to conditional branches.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_predecode
  import fetch_stage_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  output logic [31:0] target_o,
  output logic        taken_o
);

  logic [6:0] w_opcode;
  assign w_opcode = instr_i[6:0];

  // Pick the next fetch address: JAL always, backward branches (imm sign set)
  // predicted taken, everything else falls through. JALR is left to decode.
  always_comb begin
    target_o = pc_i + 32'd4;
    taken_o  = 1'b0;
    if (w_opcode == OPC_JAL) begin
      target_o = pc_i + sext_j_imm(instr_i);
      taken_o  = 1'b1;
    end else if (w_opcode == OPC_BRANCH && instr_i[31]) begin
      target_o = pc_i + sext_b_imm(instr_i);
      taken_o  = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : RV32I instruction-fetch stage. Owns the PC and the IF/ID
//               register, predicts statically (BTFN + JAL) and accepts stall
//               and redirect requests from decode.
//               Optional perf counters enabled with macro FETCH_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_ENC
) (
  input  logic        clk,
  input  logic        rstn,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall_in,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc_dec,
  output logic [31:0] instruction_dec,
  output logic        valid_dec,
  output logic        pred_taken_dec,
  output logic [15:0] redirect_cnt,
  output logic [15:0] stall_cnt
);

  logic [31:0] pc_q;
  logic [31:0] pc_dec_q;
  logic [31:0] instr_dec_q;
  logic        valid_dec_q;
  logic        pred_taken_q;
  logic [31:0] w_target;
  logic        w_taken;

  fetch_predecode u_predecode (
    .pc_i     (pc_q),
    .instr_i  (imem_rdata),
    .target_o (w_target),
    .taken_o  (w_taken)
  );

  assign imem_addr       = pc_q;
  assign pc_dec          = pc_dec_q;
  assign instruction_dec = instr_dec_q;
  assign valid_dec       = valid_dec_q;
  assign pred_taken_dec  = pred_taken_q;

  // PC and IF/ID update: redirect flushes (and wins over stall), stall holds,
  // otherwise advance to the predicted target and capture the fetched word.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q         <= RESET_PC;
      pc_dec_q     <= 32'd0;
      instr_dec_q  <= NOP_INSTR;
      valid_dec_q  <= 1'b0;
      pred_taken_q <= 1'b0;
    end else if (redirect_valid) begin
      pc_q         <= redirect_pc;
      instr_dec_q  <= NOP_INSTR;
      valid_dec_q  <= 1'b0;
      pred_taken_q <= 1'b0;
    end else if (!stall_in) begin
      pc_q         <= w_target;
      pc_dec_q     <= pc_q;
      instr_dec_q  <= imem_rdata;
      valid_dec_q  <= 1'b1;
      pred_taken_q <= w_taken;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] redirect_cnt_q;
  logic [15:0] stall_cnt_q;

  // Saturating event counters; a stall coinciding with a redirect is not a stall.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      redirect_cnt_q <= 16'd0;
      stall_cnt_q    <= 16'd0;
    end else begin
      if (redirect_valid && redirect_cnt_q != 16'hFFFF)
        redirect_cnt_q <= redirect_cnt_q + 16'd1;
      if (stall_in && !redirect_valid && stall_cnt_q != 16'hFFFF)
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign redirect_cnt = redirect_cnt_q;
  assign stall_cnt    = stall_cnt_q;
`else
  assign redirect_cnt = 16'd0;
  assign stall_cnt    = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Directed self-checking bench for fetch_stage with a
//               combinational instruction memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  localparam logic [31:0] JAL_W = 32'h010000EF;  // jal x1,+16
  localparam logic [31:0] BEQ_W = 32'hFE000CE3;  // beq x0,x0,-8
  localparam logic [31:0] NOP_W = 32'h00000013;
`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk;
  logic        rstn;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall_in;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] pc_dec;
  logic [31:0] instruction_dec;
  logic        valid_dec;
  logic        pred_taken_dec;
  logic [15:0] redirect_cnt;
  logic [15:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [256];

  fetch_stage dut (
    .clk             (clk),
    .rstn            (rstn),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .stall_in        (stall_in),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .pc_dec          (pc_dec),
    .instruction_dec (instruction_dec),
    .valid_dec       (valid_dec),
    .pred_taken_dec  (pred_taken_dec),
    .redirect_cnt    (redirect_cnt),
    .stall_cnt       (stall_cnt)
  );

  assign imem_rdata = mem[imem_addr[9:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full observable state in one call.
  task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_pcd,
                           input logic [31:0] e_ins, input logic e_v, input logic e_t);
    check({tag, ".pc"},    imem_addr,              e_pc);
    check({tag, ".pcdec"}, pc_dec,                 e_pcd);
    check({tag, ".instr"}, instruction_dec,        e_ins);
    check({tag, ".valid"}, {31'd0, valid_dec},     {31'd0, e_v});
    check({tag, ".pred"},  {31'd0, pred_taken_dec}, {31'd0, e_t});
  endtask

  task automatic check_cnt(input string tag, input int e_red, input int e_stl);
    check({tag, ".rcnt"}, {16'd0, redirect_cnt}, PERF ? e_red : 0);
    check({tag, ".scnt"}, {16'd0, stall_cnt},    PERF ? e_stl : 0);
  endtask

  initial begin
    // addi x1,x0,i everywhere, with a JAL at 0x20 and a backward beq at 0x40
    for (int i = 0; i < 256; i++) mem[i] = 32'h00000093 | (i << 20);
    mem[8'h08] = JAL_W;
    mem[8'h10] = BEQ_W;

    rstn = 1'b0; stall_in = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    step(); step();
    check_all("reset", 32'h0, 32'h0, NOP_W, 1'b0, 1'b0);
    check_cnt("reset", 0, 0);
    rstn = 1'b1;

    // straight-line fetch
    step(); check_all("seq0", 32'h4, 32'h0, mem[0], 1'b1, 1'b0);
    step(); check_all("seq1", 32'h8, 32'h4, mem[1], 1'b1, 1'b0);
    step(); step(); step();
    check_all("seq4", 32'h14, 32'h10, mem[4], 1'b1, 1'b0);

    // 3-cycle stall holds PC and IF/ID
    stall_in = 1'b1;
    step(); check_all("stall1", 32'h14, 32'h10, mem[4], 1'b1, 1'b0);
    step(); check_all("stall2", 32'h14, 32'h10, mem[4], 1'b1, 1'b0);
    step(); check_all("stall3", 32'h14, 32'h10, mem[4], 1'b1, 1'b0);
    stall_in = 1'b0;
    step(); check_all("resume", 32'h18, 32'h14, mem[5], 1'b1, 1'b0);
    check_cnt("stall", 0, 3);

    // JAL at 0x20 resolved at fetch, no bubble
    step(); step();
    check(" pre_jal.pc", imem_addr, 32'h20);
    step(); check_all("jal", 32'h30, 32'h20, JAL_W, 1'b1, 1'b1);
    step(); check_all("jal_tgt", 32'h34, 32'h30, mem[12], 1'b1, 1'b0);

    // backward beq at 0x40 predicted taken, then decode corrects it
    step(); step(); step();
    check("pre_beq.pc", imem_addr, 32'h40);
    step(); check_all("beq", 32'h38, 32'h40, BEQ_W, 1'b1, 1'b1);
    redirect_valid = 1'b1; redirect_pc = 32'h44;
    step(); check_all("redir", 32'h44, 32'h40, NOP_W, 1'b0, 1'b0);
    check_cnt("redir", 1, 3);
    redirect_valid = 1'b0;
    step(); check_all("redir_tgt", 32'h48, 32'h44, mem[17], 1'b1, 1'b0);

    // redirect coinciding with stall: redirect wins, stall not counted
    redirect_valid = 1'b1; redirect_pc = 32'h100; stall_in = 1'b1;
    step(); check_all("redir_stall", 32'h100, 32'h44, NOP_W, 1'b0, 1'b0);
    check_cnt("redir_stall", 2, 3);
    redirect_valid = 1'b0; stall_in = 1'b0;
    step(); check_all("rs_tgt", 32'h104, 32'h100, mem[64], 1'b1, 1'b0);

    // PC wraps modulo 2^32
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step(); check("wrap.pc0", imem_addr, 32'hFFFF_FFFC);
    redirect_valid = 1'b0;
    step(); check_all("wrap", 32'h0, 32'hFFFF_FFFC, mem[255], 1'b1, 1'b0);

    // unaligned PC low bits pass through
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    step(); check("unal.pc0", imem_addr, 32'h102);
    redirect_valid = 1'b0;
    step(); check_all("unal", 32'h106, 32'h102, mem[64], 1'b1, 1'b0);

    // run to 0x80, stall, then async reset mid-stall
    redirect_valid = 1'b1; redirect_pc = 32'h7C;
    step();
    redirect_valid = 1'b0;
    step(); check("pre_rst.pc", imem_addr, 32'h80);
    stall_in = 1'b1;
    step(); check_cnt("pre_rst", 5, 4);
    #2 rstn = 1'b0;
    #1;
    check_all("async_rst", 32'h0, 32'h0, NOP_W, 1'b0, 1'b0);
    check_cnt("async_rst", 0, 0);
    stall_in = 1'b0;
    step();
    rstn = 1'b1;
    step(); check_all("post_rst", 32'h4, 32'h0, mem[0], 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
